// File: rtl/axi_adc_jesd204_tpl_deframer.sv
// JESD204 receive transport-layer deframer (rx_clk domain).
// Locks to the SOF octet offset and realigns each lane word onto frame
// boundaries. Splits lane octets into per-channel 16-bit samples, then applies
// format conversion and enable gating to each channel.
// Ports:
//   rx_clk, rx_rst        clock, synchronous active-high reset
//   rx_sof/valid/data     link-layer beat (4 SOF markers, 32 bits per lane)
//   rx_ready              always 1
//   adc_enable/dfmt_*     per-channel enable and format controls
//   adc_valid/adc_data    registered per-channel strobe and samples
//   adc_locked            alignment locked
//   adc_sof_err_count/clr saturating SOF-mismatch counter and its clear
module axi_adc_jesd204_tpl_deframer #(
    parameter int unsigned NUM_LANES       = 1,
    parameter int unsigned NUM_CHANNELS    = 1,
    parameter int unsigned CHANNEL_WIDTH   = 14,
    localparam int unsigned DATA_PATH_WIDTH = 2 * NUM_LANES / NUM_CHANNELS
) (
    input  logic                                      rx_clk,
    input  logic                                      rx_rst,
    input  logic [3:0]                                rx_sof,
    input  logic                                      rx_valid,
    input  logic [NUM_LANES*32-1:0]                   rx_data,
    output logic                                      rx_ready,
    input  logic [NUM_CHANNELS-1:0]                   adc_enable,
    input  logic [NUM_CHANNELS-1:0]                   adc_dfmt_type,
    input  logic [NUM_CHANNELS-1:0]                   adc_dfmt_se,
    output logic [NUM_CHANNELS-1:0]                   adc_valid,
    output logic [NUM_CHANNELS*DATA_PATH_WIDTH*16-1:0] adc_data,
    output logic                                      adc_locked,
    output logic [15:0]                               adc_sof_err_count,
    input  logic                                      adc_sof_err_clr
);

    localparam int unsigned NUM_SAMPLES = 2 * NUM_LANES;
    localparam int unsigned LANE_W      = NUM_LANES * 32;
    localparam int unsigned OUT_W       = NUM_CHANNELS * DATA_PATH_WIDTH * 16;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    state_t              state, state_nxt;
    logic [1:0]          off;
    logic [LANE_W-1:0]   prev;
    logic [LANE_W-1:0]   aligned;
    logic [OUT_W-1:0]    data_nxt;
    logic [1:0]          sof_off;
    logic                sof_hit;
    logic                mismatch;
    logic                capture;
    logic                strobe;

    // Index of the lowest set SOF bit.
    function automatic logic [1:0] lowest_set(input logic [3:0] s);
        lowest_set = 2'd0;
        for (int j = 3; j >= 0; j--) begin
            if (s[j]) lowest_set = 2'(j);
        end
    endfunction

    assign rx_ready   = 1'b1;
    assign adc_locked = (state == LOCKED);

    // Beat classification; a mismatch recaptures the offset like the first lock.
    assign sof_off  = lowest_set(rx_sof);
    assign sof_hit  = rx_valid & (|rx_sof);
    assign mismatch = (state == LOCKED) & sof_hit & (sof_off != off);
    assign capture  = ((state == UNLOCKED) & sof_hit) | mismatch;
    assign strobe   = (state == LOCKED) & rx_valid & ~capture;

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            UNLOCKED: if (sof_hit) state_nxt = LOCKED;
            LOCKED:   state_nxt = LOCKED;
            default:  state_nxt = UNLOCKED;
        endcase
    end

    // Per-lane realignment: the frame starts off octets into the previous word.
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        assign aligned[l*32 +: 32] =
            32'({rx_data[l*32 +: 32], prev[l*32 +: 32]} >> {off, 3'b000});
    end

    // Sample i = 2*lane + k feeds channel i / DATA_PATH_WIDTH at output slot i.
    for (genvar g = 0; g < NUM_SAMPLES; g++) begin : g_sample
        localparam int unsigned LN = g / 2;
        localparam int unsigned K  = g % 2;
        localparam int unsigned CH = g / DATA_PATH_WIDTH;

        logic [CHANNEL_WIDTH-1:0] v;
        logic [CHANNEL_WIDTH-1:0] vt;
        logic [15:0]              ext;

        assign v   = CHANNEL_WIDTH'({aligned[LN*32 + 16*K +: 8],
                                     aligned[LN*32 + 16*K + 8 +: 8]} >> (16 - CHANNEL_WIDTH));
        assign vt  = {v[CHANNEL_WIDTH-1] ^ adc_dfmt_type[CH], v[CHANNEL_WIDTH-2:0]};
        assign ext = adc_dfmt_se[CH] ? 16'($signed(vt)) : 16'(vt);
        assign data_nxt[g*16 +: 16] = adc_enable[CH] ? ext : 16'd0;
    end

    // State, alignment and output registers.
    always_ff @(posedge rx_clk) begin
        if (rx_rst) begin
            state             <= UNLOCKED;
            off               <= 2'd0;
            prev              <= '0;
            adc_valid         <= '0;
            adc_data          <= '0;
            adc_sof_err_count <= 16'd0;
        end else begin
            state <= state_nxt;
            if (capture)  off  <= sof_off;
            if (rx_valid) prev <= rx_data;
            adc_valid <= strobe ? adc_enable : '0;
            if (strobe) adc_data <= data_nxt;
            if (adc_sof_err_clr) begin
                adc_sof_err_count <= 16'd0;
            end else if (mismatch && (adc_sof_err_count != 16'hFFFF)) begin
                adc_sof_err_count <= adc_sof_err_count + 16'd1;
            end
        end
    end

endmodule
